instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, sets the memory depth: 2**DEPTH_LOG2 words.
REQ-002 Parameter DATA_W, default 32, sets the instruction word width in bits.
REQ-003 Parameter NOP_WORD, default 32'h00000000, is the fill and error word.
REQ-004 clk  in  1  the single clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 fetch_req  in  1  requests one instruction fetch in this cycle.
REQ-007 fetch_addr  in  32  byte address of the fetch.
REQ-008 fetch_ready  out  1  high when a fetch_req in this cycle will be accepted.
REQ-009 fetch_valid  out  1  high when instr holds the result of an accepted fetch.
REQ-010 instr  out  DATA_W  the fetched instruction word.
REQ-011 fetch_err  out  1  the fetch was misaligned or out of range; valid only with fetch_valid.
REQ-012 load_start  in  1  starts a program load at word 0.
REQ-013 load_valid  in  1  load_data holds a word to write.
REQ-014 load_last  in  1  the current load word is the final word.
REQ-015 load_data  in  DATA_W  the program word to write.
REQ-016 load_ready  out  1  the block accepts a load word in this cycle.
REQ-017 load_done  out  1  one-cycle pulse when a load completes.
REQ-018 load_ovf  out  1  sticky flag: the load pointer wrapped.

Function
REQ-019 The FSM has three states: CLEAR, IDLE and LOAD.
REQ-020 CLEAR writes NOP_WORD to one word per cycle, starting at word 0, and moves to IDLE after word 2**DEPTH_LOG2-1; clearing takes exactly 2**DEPTH_LOG2 cycles.
REQ-021 fetch_ready = (state==IDLE); a fetch_req while fetch_ready=0 is ignored and yields no fetch_valid.
REQ-022 An accepted fetch has a latency of 1 cycle: fetch_valid=1 on the next cycle only, and instr=mem[fetch_addr[DEPTH_LOG2+1:2]].
REQ-023 A fetch is misaligned when fetch_addr[1:0]!=0 and out of range when any bit of fetch_addr[31:DEPTH_LOG2+2] is 1.
REQ-024 For a misaligned or out-of-range fetch: instr=NOP_WORD, fetch_err=1, and no memory word is read.
REQ-025 While fetch_valid=0, instr=NOP_WORD and fetch_err=0.
REQ-026 In IDLE, load_start moves the FSM to LOAD, clears the write pointer to 0 and clears load_ovf.
REQ-027 When a fetch_req and a load_start arrive in the same IDLE cycle, the fetch is accepted and returned normally on the next cycle.
REQ-028 load_ready = (state==LOAD).
REQ-029 Each cycle with load_valid & load_ready writes load_data to mem[ptr] and increments ptr modulo 2**DEPTH_LOG2.
REQ-030 A write at ptr=2**DEPTH_LOG2-1 without load_last sets load_ovf, which stays set until the next load_start or reset.
REQ-031 An accepted write with load_last=1 returns the FSM to IDLE and pulses load_done on the following cycle.
REQ-032 load_start while in LOAD or CLEAR is ignored.
REQ-033 load_last without load_valid has no effect.
REQ-034 A word written in cycle N is visible to a fetch accepted in cycle N+1 or later.

Reset
REQ-035 reset forces state=CLEAR and the clear pointer to 0.
REQ-036 reset drives the outputs to: fetch_valid=0, instr=NOP_WORD, fetch_err=0, load_done=0, load_ovf=0.
REQ-037 reset forces fetch_ready=0 and load_ready=0 until CLEAR completes.
REQ-038 reset asserted mid-load or mid-clear aborts the operation and restarts CLEAR; no load_done is produced.
REQ-039 Memory contents are not reset directly; only the CLEAR sequence rewrites them.

Structure
REQ-040 A shared package mips_mem_pkg holds the state enum (CLEAR, IDLE, LOAD), the default NOP_WORD and DEFAULT_DEPTH_LOG2.
REQ-041 The storage array is one sub-module, imem_ram_1r1w: one synchronous read port and one synchronous write port, with write-before-read on the same address not required.
REQ-042 The single write port is muxed between the CLEAR pointer and the LOAD pointer by state.

Verification
REQ-043 Reset, then count cycles: fetch_ready rises exactly 256 cycles after reset falls; a fetch of 0x0 then returns 32'h00000000 with fetch_err=0.
REQ-044 Load words 0x2004001C, 0x8C840000, 0x08000003 with load_last on the third: load_done pulses once; fetches of 0x0, 0x4 and 0x8 return those words, one cycle after each request.
REQ-045 Fetch 0x6 and fetch 0x400 (DEPTH_LOG2=8): each returns instr=0 with fetch_err=1.
REQ-046 Load 257 words without load_last: load_ovf=1, and word 0 holds the 257th word.
REQ-047 Assert reset in the middle of a load: no load_done; fetch_ready returns only after 256 CLEAR cycles; all words read NOP.
REQ-048 Assert fetch_req and load_start in the same IDLE cycle: the fetch returns valid data next cycle, and load_ready=1 from the next cycle on.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the instruction memory loader.
// Holds the controller state encoding and default sizing / fill values.
// No logic of its own; no latency or backpressure.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int          DEFAULT_DEPTH_LOG2 = 8;
    localparam logic [31:0] DEFAULT_NOP_WORD   = 32'h0000_0000;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Instruction storage: one synchronous write port and one synchronous read port.
// Read data appears one cycle after re; a same-address write/read returns the old word.
// No backpressure; both ports accept every cycle.
module imem_ram_1r1w #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with NOP clear after reset, streamed program load and a fetch port.
// Fetch latency 1 cycle; load_done follows the last accepted load word by 1 cycle.
// fetch_ready only in IDLE, load_ready only in LOAD; requests outside those states are dropped.
module instr_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int                DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(DEFAULT_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instr,
    output logic              fetch_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_ovf
);

    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] clr_ptr;
    logic [DEPTH_LOG2-1:0] ld_ptr;
    logic                  fetch_acc;
    logic                  fetch_bad;
    logic                  ld_acc;
    logic                  ld_start_acc;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_W-1:0]     ram_wdata;
    logic                  ram_re;
    logic [DATA_W-1:0]     ram_q;

    assign fetch_ready  = (state == IDLE);
    assign load_ready   = (state == LOAD);
    assign fetch_acc    = fetch_req & fetch_ready;
    assign fetch_bad    = (fetch_addr[1:0] != 2'b00) | (|(fetch_addr >> (DEPTH_LOG2 + 2)));
    assign ld_acc       = load_valid & load_ready;
    assign ld_start_acc = load_start & fetch_ready;

    // Bad fetches never touch the RAM; their result is forced to NOP below.
    assign ram_re = fetch_acc & ~fetch_bad;
    assign instr  = (fetch_valid && !fetch_err) ? ram_q : NOP_WORD;

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_waddr = clr_ptr;
        ram_wdata = NOP_WORD;
        case (state)
            CLEAR: begin
                ram_we = 1'b1;
                if (clr_ptr == PTR_MAX) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ram_we    = load_valid;
                ram_waddr = ld_ptr;
                ram_wdata = load_data;
                if (load_valid && load_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = CLEAR;
        endcase
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            ld_ptr      <= '0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            load_done   <= 1'b0;
            load_ovf    <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_valid <= fetch_acc;
            fetch_err   <= fetch_acc & fetch_bad;
            load_done   <= ld_acc & load_last;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + PTR_ONE;
            end
            if (ld_start_acc) begin
                ld_ptr   <= '0;
                load_ovf <= 1'b0;
            end else if (ld_acc) begin
                ld_ptr <= ld_ptr + PTR_ONE;
                if (ld_ptr == PTR_MAX && !load_last) begin
                    load_ovf <= 1'b1;
                end
            end
        end
    end

    imem_ram_1r1w #(
        .AW (DEPTH_LOG2),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr[DEPTH_LOG2+1:2]),
        .rdata (ram_q)
    );

endmodule
